inst_encoder_loader: RTL and testbench

Inverse of the instruction decoder. It accepts decoded-form micro-ops and packs each one into a 32-bit RV32I word: R-type ALU ops, I-type ALU ops including shifts, and LUI.
Each packed word is written sequentially into instruction memory through a single write port. The block sits between the test/boot sequencer and the instruction RAM, and is used to load programs for the CPU lab.

---
 rtl/inst_encoder_loader_pkg.sv | 24 ++
 rtl/inst_field_pack.sv | 48 ++++
 rtl/inst_encoder_loader.sv | 111 +++++++++++
 tb/tb_inst_encoder_loader.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_loader_pkg.sv
// Shared RV32I field encodings and loader FSM state type.
// Used by inst_field_pack and inst_encoder_loader (see ENC_LEGAL_CHECK_EN there).
package inst_encoder_loader_pkg;

   localparam int unsigned INSN_W = 32;
   localparam int unsigned OPC_W  = 7;

   localparam logic [OPC_W-1:0]  INST_R           = 7'b0110011;
   localparam logic [OPC_W-1:0]  INST_I           = 7'b0010011;
   localparam logic [OPC_W-1:0]  INST_U1          = 7'b0110111;
   localparam logic [6:0]        FUNCT7_ALT       = 7'b0100000;
   localparam logic [2:0]        FUNCT3_ADD       = 3'b000;
   localparam logic [2:0]        SHIFT_FUNCT3_SLL = 3'b001;
   localparam logic [2:0]        SHIFT_FUNCT3_SR  = 3'b101;
   localparam logic [INSN_W-1:0] NOP_WORD         = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

   // Shift funct3 values carry shamt plus funct7 in the I-type immediate.
   function automatic logic is_shift(input logic [2:0] funct3);
      return (funct3 == SHIFT_FUNCT3_SLL) || (funct3 == SHIFT_FUNCT3_SR);
   endfunction

endpackage

// File: rtl/inst_field_pack.sv
// Combinational packer: decoded micro-op fields -> RV32I word plus illegal flag.
// With ENC_LEGAL_CHECK_EN defined, malformed ops are flagged; otherwise R>I>U priority.
module inst_field_pack
   import inst_encoder_loader_pkg::*;
(
   input  logic              is_r,
   input  logic              is_i,
   input  logic              is_u,
   input  logic [3:0]        alu_op,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [19:0]       imm,
   output logic [INSN_W-1:0] word,
   output logic              illegal
);

   logic [2:0]  funct3;
   logic        alt;
   logic [6:0]  funct7;
   logic [11:0] imm_i;

   assign funct3 = alu_op[2:0];
   assign alt    = alu_op[3];
   assign funct7 = alt ? FUNCT7_ALT : 7'b0;

   always_comb begin
      imm_i   = imm[11:0];
      word    = NOP_WORD;
      illegal = 1'b0;

      if (is_shift(funct3)) imm_i = {funct7, imm[4:0]};
`ifndef ENC_LEGAL_CHECK_EN
      else imm_i[10] = imm[10] | alt;
`endif

`ifdef ENC_LEGAL_CHECK_EN
      if (!({is_r, is_i, is_u} inside {3'b100, 3'b010, 3'b001})) illegal = 1'b1;
      if (is_r && alt && (funct3 != FUNCT3_ADD) && (funct3 != SHIFT_FUNCT3_SR)) illegal = 1'b1;
      if (is_i && alt && (funct3 != SHIFT_FUNCT3_SR)) illegal = 1'b1;
`endif

      if (is_r)      word = {funct7, rs2, rs1, funct3, rd, INST_R};
      else if (is_i) word = {imm_i, rs1, funct3, rd, INST_I};
      else if (is_u) word = {imm, rd, INST_U1};
   end

endmodule

// File: rtl/inst_encoder_loader.sv
// Encodes decoded micro-ops into RV32I words and streams them into instruction RAM.
// Optional build macro: ENC_LEGAL_CHECK_EN enables illegal-op detection and the sticky err flag.
module inst_encoder_loader
   import inst_encoder_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DEPTH  = 64
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_is_r,
   input  logic              in_is_i,
   input  logic              in_is_u,
   input  logic [3:0]        in_alu_op,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [19:0]       in_imm,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   state_t            state;
   logic              ready_q;
   logic [31:0]       enc_word;
   logic              enc_illegal;
   logic [CNT_W-1:0]  count_inc;

   inst_field_pack u_pack (
      .is_r    (in_is_r),
      .is_i    (in_is_i),
      .is_u    (in_is_u),
      .alu_op  (in_alu_op),
      .rd      (in_rd),
      .rs1     (in_rs1),
      .rs2     (in_rs2),
      .imm     (in_imm),
      .word    (enc_word),
      .illegal (enc_illegal)
   );

   // A start cycle never accepts a micro-op.
   assign in_ready  = ready_q && !start;
   assign count_inc = count + CNT_W'(1);

   // Count doubles as the write pointer: both clear and advance together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ready_q   <= 1'b1;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         count     <= '0;
         full      <= 1'b0;
         err       <= 1'b0;
      end else if (start) begin
         state   <= IDLE;
         ready_q <= 1'b1;
         mem_we  <= 1'b0;
         count   <= '0;
         full    <= 1'b0;
         err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  if (enc_illegal) begin
                     err <= 1'b1;
                  end else begin
                     mem_we    <= 1'b1;
                     mem_addr  <= count[ADDR_W-1:0];
                     mem_wdata <= enc_word;
                     ready_q   <= 1'b0;
                     state     <= WRITE;
                  end
               end
            end
            WRITE: begin
               mem_we <= 1'b0;
               count  <= count_inc;
               if (count_inc == CNT_W'(DEPTH)) begin
                  full  <= 1'b1;
                  state <= FULL;
               end else begin
                  ready_q <= 1'b1;
                  state   <= IDLE;
               end
            end
            FULL: begin
               ready_q <= 1'b0;
            end
            default: begin
               ready_q <= 1'b1;
               mem_we  <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Self-checking bench for inst_encoder_loader: directed test-plan cases plus random ops
// checked against an arithmetic encoding model and a transaction-level write scoreboard.
module tb_inst_encoder_loader;

   localparam int unsigned ADDR_W = 6;
   localparam int unsigned DEPTH  = 4;

   typedef struct {
      bit        r, i, u;
      bit [3:0]  alu;
      bit [4:0]  rd, rs1, rs2;
      bit [19:0] imm;
   } op_t;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       word;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst, start, in_valid, in_ready;
   logic              in_is_r, in_is_i, in_is_u;
   logic [3:0]        in_alu_op;
   logic [4:0]        in_rd, in_rs1, in_rs2;
   logic [19:0]       in_imm;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [ADDR_W:0]   count;
   logic              full, err;

   int  n_checks = 0;
   int  n_errors = 0;
   wr_t exp_q[$];
   int  m_count = 0;
   bit  m_err = 0;
   bit  wr_pending = 0;
   op_t cur_op;
   bit  use_lit = 0;
   logic [31:0] lit_word = '0;

   inst_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_is_r   (in_is_r),
      .in_is_i   (in_is_i),
      .in_is_u   (in_is_u),
      .in_alu_op (in_alu_op),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_imm    (in_imm),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .count     (count),
      .full      (full),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference encoding computed field-by-field with plain arithmetic.
   function automatic void model(input op_t op, output logic [31:0] w, output bit legal);
      logic [31:0] f3, alt, rd, rs1, rs2, imm, imm12;
      int nsel;
      f3    = 32'(op.alu % 8);
      alt   = 32'(op.alu / 8);
      rd    = 32'(op.rd);
      rs1   = 32'(op.rs1);
      rs2   = 32'(op.rs2);
      imm   = 32'(op.imm);
      nsel  = int'(op.r) + int'(op.i) + int'(op.u);
      legal = 1'b1;
`ifdef ENC_LEGAL_CHECK_EN
      if (nsel != 1) legal = 1'b0;
      if (op.r && alt == 1 && f3 != 0 && f3 != 5) legal = 1'b0;
      if (op.i && alt == 1 && f3 != 5) legal = 1'b0;
`endif
      if (f3 == 1 || f3 == 5) imm12 = alt * 1024 + (imm % 32);
      else                    imm12 = (imm % 4096) | (alt * 1024);
      if (op.r)      w = 32'h33 + rd * 128 + f3 * 4096 + rs1 * 32768 + rs2 * 1048576 + alt * 1073741824;
      else if (op.i) w = 32'h13 + rd * 128 + f3 * 4096 + rs1 * 32768 + imm12 * 1048576;
      else if (op.u) w = 32'h37 + rd * 128 + imm * 4096;
      else           w = 32'h13;
   endfunction

   // One clock: predict handshake, let the edge happen, then score outputs.
   task automatic tick(output bit hs);
      logic [31:0] w;
      bit legal;
      wr_t e;
      #1;
      if (!rst) check_eq("in_ready", 32'(in_ready), 32'(!start && !wr_pending && m_count < DEPTH));
      hs = in_valid && in_ready && !rst;
      if (rst || start) begin
         m_count    = 0;
         m_err      = 0;
         wr_pending = 0;
         exp_q.delete();
      end else begin
         if (wr_pending) begin
            m_count++;
            wr_pending = 0;
         end
         if (hs) begin
            model(cur_op, w, legal);
            if (legal) begin
               e.addr = ADDR_W'(m_count);
               e.word = use_lit ? lit_word : w;
               exp_q.push_back(e);
            end else begin
               m_err = 1;
            end
         end
      end
      @(negedge clk);
      if (mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_we", 32'(mem_we), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_eq("we_addr", 32'(mem_addr), 32'(e.addr));
            check_eq("we_data", mem_wdata, e.word);
            wr_pending = 1;
         end
      end else if (exp_q.size() != 0) begin
         check_eq("missing_we", 32'(mem_we), 32'd1);
         exp_q.delete();
      end
      check_eq("count", 32'(count), 32'(m_count));
      check_eq("full", 32'(full), 32'(m_count == DEPTH));
      check_eq("err", 32'(err), 32'(m_err));
   endtask

   task automatic idle(input int n);
      bit hs;
      for (int k = 0; k < n; k++) tick(hs);
   endtask

   task automatic pulse_start();
      bit hs;
      start = 1'b1;
      tick(hs);
      check_eq("start_no_xfer", 32'(hs), 32'd0);
      start = 1'b0;
   endtask

   // Offer an op until accepted or max_wait cycles pass; valid stays high if not taken.
   task automatic send(input op_t op, input bit ul, input logic [31:0] lw,
                       input int max_wait, output bit acc);
      cur_op    = op;
      use_lit   = ul;
      lit_word  = lw;
      in_is_r   = op.r;
      in_is_i   = op.i;
      in_is_u   = op.u;
      in_alu_op = op.alu;
      in_rd     = op.rd;
      in_rs1    = op.rs1;
      in_rs2    = op.rs2;
      in_imm    = op.imm;
      in_valid  = 1'b1;
      acc       = 1'b0;
      for (int k = 0; k < max_wait && !acc; k++) tick(acc);
      if (acc) in_valid = 1'b0;
   endtask

   task automatic send_ok(input op_t op, input bit ul, input logic [31:0] lw);
      bit acc;
      send(op, ul, lw, 8, acc);
      check_eq("accept", 32'(acc), 32'd1);
      in_valid = 1'b0;
   endtask

   function automatic op_t mk(input bit r, i, u, input bit [3:0] alu,
                              input bit [4:0] rd, rs1, rs2, input bit [19:0] imm);
      op_t o;
      o.r = r; o.i = i; o.u = u; o.alu = alu;
      o.rd = rd; o.rs1 = rs1; o.rs2 = rs2; o.imm = imm;
      return o;
   endfunction

   function automatic op_t rand_op();
      op_t o;
      int sel;
      sel = $urandom_range(0, 9);
      o.r = (sel <= 2);
      o.i = (sel >= 3 && sel <= 5);
      o.u = (sel == 6 || sel == 7);
      if (sel >= 8) begin
         o.r = 1'($urandom); o.i = 1'($urandom); o.u = 1'($urandom);
      end
      o.alu = 4'($urandom);
      o.alu[3] = ($urandom_range(0, 3) == 0);
      o.rd = 5'($urandom); o.rs1 = 5'($urandom); o.rs2 = 5'($urandom);
      o.imm = 20'($urandom);
`ifndef ENC_LEGAL_CHECK_EN
      if (o.i && !o.r && o.alu[2:0] != 3'b001 && o.alu[2:0] != 3'b101) o.alu[3] = 1'b0;
`endif
      return o;
   endfunction

   initial begin
      bit acc;
      op_t o;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0;
      in_is_r = 1'b0; in_is_i = 1'b0; in_is_u = 1'b0; in_alu_op = '0;
      in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
      cur_op = mk(0, 0, 0, 0, 0, 0, 0, 0);

      idle(2);
      check_eq("rst_ready", 32'(in_ready), 32'd1);
      check_eq("rst_we", 32'(mem_we), 32'd0);
      check_eq("rst_addr", 32'(mem_addr), 32'd0);
      check_eq("rst_wdata", mem_wdata, 32'd0);
      rst = 1'b0;
      idle(1);

      // Test-plan encodings
      send_ok(mk(1, 0, 0, 4'b0000, 3, 1, 2, 0), 1, 32'h002081B3);
      idle(2);
      check_eq("cnt_add", 32'(count), 32'd1);
      send_ok(mk(1, 0, 0, 4'b1000, 5, 6, 7, 0), 1, 32'h407302B3);
      send_ok(mk(0, 1, 0, 4'b0000, 1, 0, 0, 20'h00FFF), 1, 32'hFFF00093);
      idle(2);
      check_eq("cnt_addi", 32'(count), 32'd3);
      pulse_start();
      send_ok(mk(0, 1, 0, 4'b1101, 2, 1, 0, 20'h3), 1, 32'h4030D113);
      send_ok(mk(0, 0, 1, 4'b1010, 4, 0, 0, 20'h12345), 1, 32'h12345237);
      idle(2);

      // Fill to DEPTH back to back; fifth op must wait until start
      pulse_start();
      for (int k = 0; k < DEPTH; k++) send_ok(mk(0, 1, 0, 4'b0000, 5'(k + 1), 5'(k), 0, 20'(k * 7)), 0, '0);
      send(mk(1, 0, 0, 4'b0111, 9, 10, 11, 0), 0, '0, 6, acc);
      check_eq("op5_pending", 32'(acc), 32'd0);
      check_eq("full_flag", 32'(full), 32'd1);
      check_eq("full_ready", 32'(in_ready), 32'd0);
      pulse_start();
      for (int k = 0; k < 4 && !acc; k++) tick(acc);
      check_eq("op5_accept", 32'(acc), 32'd1);
      in_valid = 1'b0;
      idle(2);

      // Start with valid high in IDLE must not transfer
      in_valid = 1'b1;
      pulse_start();
      in_valid = 1'b0;
      idle(1);

      // Malformed ops
      send_ok(mk(1, 1, 0, 4'b0000, 1, 2, 3, 0), 0, '0);
      idle(2);
      send_ok(mk(0, 1, 0, 4'b1000, 1, 2, 0, 20'h5), 0, '0);
      idle(2);
`ifdef ENC_LEGAL_CHECK_EN
      check_eq("err_set", 32'(err), 32'd1);
`else
      check_eq("err_zero", 32'(err), 32'd0);
`endif
      send_ok(mk(0, 0, 1, 4'b0000, 7, 0, 0, 20'hABCDE), 0, '0);
      idle(2);
      send_ok(mk(0, 0, 0, 4'b0000, 7, 0, 0, 20'h0), 0, '0);
      idle(2);

      // Abort a write with start, then with rst
      pulse_start();
      send_ok(mk(1, 0, 0, 4'b0001, 1, 1, 1, 0), 0, '0);
      idle(1);
      send_ok(mk(1, 0, 0, 4'b0100, 2, 2, 2, 0), 0, '0);
      pulse_start();
      check_eq("abort_we", 32'(mem_we), 32'd0);
      check_eq("abort_cnt", 32'(count), 32'd0);
      idle(1);
      send_ok(mk(0, 0, 1, 4'b0000, 3, 0, 0, 20'h00042), 0, '0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check_eq("rst_abort_we", 32'(mem_we), 32'd0);
      check_eq("rst_abort_cnt", 32'(count), 32'd0);
      idle(1);

      // Random traffic
      for (int n = 0; n < 120; n++) begin
         if (m_count + int'(wr_pending) == DEPTH || $urandom_range(0, 15) == 0) begin
            idle(1);
            pulse_start();
         end
         o = rand_op();
         send_ok(o, 0, '0);
         idle($urandom_range(0, 2));
      end
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1);
   end

endmodule
